mips_avalon_slave_ram: RTL

MIPS_AVALON_SLAVE_RAM -- requirements
Module: mips_avalon_slave_ram

---
 rtl/mips_avalon_slave_ram_if.sv | 36 +++
 rtl/mips_avalon_slave_ram.sv | 83 ++++++++
 2 files changed

// File: rtl/mips_avalon_slave_ram_if.sv
// rtl/mips_avalon_slave_ram_if.sv - CPU-side memory bus between a bus master and the RAM slave
interface mips_avalon_slave_ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        bus_error;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  waitrequest,
        input  readdata,
        input  readdatavalid,
        input  bus_error
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output waitrequest,
        output readdata,
        output readdatavalid,
        output bus_error
    );
endinterface

// File: rtl/mips_avalon_slave_ram.sv
// rtl/mips_avalon_slave_ram.sv - word-addressed RAM slave with programmable stall and sticky bus error
module mips_avalon_slave_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    mips_avalon_slave_ram_if.slave       bus
);
    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_CYCLES);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state;
    logic [3:0]              count;
    logic [31:0]             mem [DEPTH];

    logic                    request;
    logic                    accept;
    logic                    in_range;
    logic                    misaligned;
    logic                    conflict;
    logic                    do_write;
    logic                    do_read;
    logic [31:0]             offset;
    logic [DEPTH_LOG2-1:0]   index;

    assign request    = bus.read | bus.write;
    assign accept     = request & ~reset & (count == WAIT_LIMIT);
    assign bus.waitrequest = request & ~reset & (count != WAIT_LIMIT);

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    assign offset     = bus.address - BASE_ADDR;
    assign in_range   = (offset >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign index      = offset[DEPTH_LOG2+1:2];
    assign misaligned = |bus.address[1:0];
    assign conflict   = bus.read & bus.write;

    assign do_write   = accept & bus.write & in_range;
    assign do_read    = accept & bus.read & ~bus.write;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenable[i]) begin
                    mem[index][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            count             <= 4'd0;
            bus.readdata      <= 32'd0;
            bus.readdatavalid <= 1'b0;
            bus.bus_error     <= 1'b0;
        end else begin
            bus.readdatavalid <= 1'b0;
            if (accept) begin
                state <= S_IDLE;
                count <= 4'd0;
                if (do_read) begin
                    bus.readdata      <= in_range ? mem[index] : 32'd0;
                    bus.readdatavalid <= 1'b1;
                end
                if (~in_range | misaligned | conflict) begin
                    bus.bus_error <= 1'b1;
                end
            end else if (request) begin
                state <= S_WAIT;
                count <= count + 4'd1;
            end else if (state == S_WAIT) begin
                // Master withdrew mid-stall: abandon the transfer silently.
                state <= S_IDLE;
                count <= 4'd0;
            end
        end
    end
endmodule
